// File: rtl/game_move_controller.sv
// Key-driven cursor, selection and move-request sequencer for the board datapath.
// Owns turn control: active player, per-turn move budget and turn timeout.
module game_move_controller #(
  parameter int BORAD_WIDTH = 10,
  parameter int MOVES_PER_TURN = 3,
  parameter int TURN_CYCLES = 100000000,
  localparam int CW = $clog2(BORAD_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          keyboard_locker,
  input  logic [2:0]    keyboard_data,
  output logic          move_req,
  input  logic          move_ack,
  input  logic          move_ok,
  output logic [CW-1:0] move_src_x,
  output logic [CW-1:0] move_src_y,
  output logic [1:0]    move_dir,
  output logic          move_half,
  output logic [CW-1:0] cursor_x,
  output logic [CW-1:0] cursor_y,
  output logic          selected,
  output logic          cur_player,
  output logic          turn_switch
);
  localparam int TW = $clog2(TURN_CYCLES);
  localparam logic [CW-1:0] MAXC = CW'(BORAD_WIDTH - 1);
  localparam logic [TW-1:0] TLAST = TW'(TURN_CYCLES - 1);
  localparam logic [3:0] MLAST = 4'(MOVES_PER_TURN);

  typedef enum logic [1:0] {
    S_CURSOR,
    S_SELECTED,
    S_WAIT_ACK
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [CW-1:0] srcx_q, srcx_d, srcy_q, srcy_d;
  logic [1:0] dir_q, dir_d;
  logic sel_q, sel_d, half_q, half_d;
  logic mhalf_q, mhalf_d;
  logic req_q, req_d, ply_q, ply_d;
  logic tsw_q, tsw_d, lock_q;
  logic [3:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;

  // {in_bounds, x, y} of one step from (x,y); clamps to the origin cell
  function automatic logic [2*CW:0] step(
    input logic [CW-1:0] x,
    input logic [CW-1:0] y,
    input logic [1:0] d
  );
    logic ok;
    logic [CW-1:0] nx, ny;
    ok = 1'b0;
    nx = x;
    ny = y;
    unique case (d)
      2'd0: begin ok = (y != '0); ny = y - CW'(1); end
      2'd1: begin ok = (y != MAXC); ny = y + CW'(1); end
      2'd2: begin ok = (x != '0); nx = x - CW'(1); end
      2'd3: begin ok = (x != MAXC); nx = x + CW'(1); end
    endcase
    if (!ok) begin
      nx = x;
      ny = y;
    end
    return {ok, nx, ny};
  endfunction

  logic ev, tmo, do_sw;
  logic k_dir, k_sel, k_half, k_end, k_cancel;
  logic [1:0] sdir;
  logic [2*CW:0] cstep, sstep;
  logic [3:0] cnt_inc;

  assign ev = keyboard_locker & ~lock_q;
  assign tmo = (tmr_q == TLAST);
  assign k_dir = ~keyboard_data[2];
  assign k_sel = (keyboard_data == 3'd4);
  assign k_half = (keyboard_data == 3'd5);
  assign k_end = (keyboard_data == 3'd6);
  assign k_cancel = (keyboard_data == 3'd7);
  assign sdir = (state_q == S_WAIT_ACK) ? dir_q : keyboard_data[1:0];
  assign cstep = step(cx_q, cy_q, keyboard_data[1:0]);
  assign sstep = step(sx_q, sy_q, sdir);
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cx_d = cx_q;
    cy_d = cy_q;
    sx_d = sx_q;
    sy_d = sy_q;
    srcx_d = srcx_q;
    srcy_d = srcy_q;
    dir_d = dir_q;
    sel_d = sel_q;
    half_d = half_q;
    mhalf_d = mhalf_q;
    req_d = req_q;
    ply_d = ply_q;
    tsw_d = 1'b0;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    do_sw = 1'b0;
    unique case (state_q)
      S_CURSOR: begin
        tmr_d = tmr_q + TW'(1);
        if (tmo) begin
          do_sw = 1'b1;
        end else if (ev) begin
          unique case (1'b1)
            k_dir: begin
              if (cstep[2*CW]) begin
                cx_d = cstep[2*CW-1:CW];
                cy_d = cstep[CW-1:0];
              end
            end
            k_sel: begin
              sx_d = cx_q;
              sy_d = cy_q;
              sel_d = 1'b1;
              state_d = S_SELECTED;
            end
            k_half: half_d = ~half_q;
            k_end: do_sw = 1'b1;
            k_cancel: ;
          endcase
        end
      end
      S_SELECTED: begin
        tmr_d = tmr_q + TW'(1);
        if (tmo) begin
          do_sw = 1'b1;
        end else if (ev) begin
          unique case (1'b1)
            k_dir: begin
              if (sstep[2*CW]) begin
                req_d = 1'b1;
                srcx_d = sx_q;
                srcy_d = sy_q;
                dir_d = keyboard_data[1:0];
                mhalf_d = half_q;
                state_d = S_WAIT_ACK;
              end
            end
            k_sel, k_cancel: begin
              sel_d = 1'b0;
              state_d = S_CURSOR;
            end
            k_half: half_d = ~half_q;
            k_end: do_sw = 1'b1;
          endcase
        end
      end
      S_WAIT_ACK: begin
        // Timer frozen here; a due timeout lands on the ack cycle
        if (move_ack) begin
          req_d = 1'b0;
          state_d = S_SELECTED;
          if (move_ok) begin
            cx_d = sstep[2*CW-1:CW];
            cy_d = sstep[CW-1:0];
            sx_d = sstep[2*CW-1:CW];
            sy_d = sstep[CW-1:0];
            half_d = 1'b0;
            cnt_d = cnt_inc;
            if (cnt_inc == MLAST) do_sw = 1'b1;
          end
          if (tmo) do_sw = 1'b1;
        end
      end
      default: state_d = S_CURSOR;
    endcase
    if (do_sw) begin
      ply_d = ~ply_q;
      tsw_d = 1'b1;
      cnt_d = '0;
      tmr_d = '0;
      sel_d = 1'b0;
      half_d = 1'b0;
      state_d = S_CURSOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CURSOR;
      cx_q <= '0;
      cy_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      srcx_q <= '0;
      srcy_q <= '0;
      dir_q <= '0;
      sel_q <= 1'b0;
      half_q <= 1'b0;
      mhalf_q <= 1'b0;
      req_q <= 1'b0;
      ply_q <= 1'b0;
      tsw_q <= 1'b0;
      cnt_q <= '0;
      tmr_q <= '0;
      lock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      srcx_q <= srcx_d;
      srcy_q <= srcy_d;
      dir_q <= dir_d;
      sel_q <= sel_d;
      half_q <= half_d;
      mhalf_q <= mhalf_d;
      req_q <= req_d;
      ply_q <= ply_d;
      tsw_q <= tsw_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      lock_q <= keyboard_locker;
    end
  end

  assign move_req = req_q;
  assign move_src_x = srcx_q;
  assign move_src_y = srcy_q;
  assign move_dir = dir_q;
  assign move_half = mhalf_q;
  assign cursor_x = cx_q;
  assign cursor_y = cy_q;
  assign selected = sel_q;
  assign cur_player = ply_q;
  assign turn_switch = tsw_q;
endmodule

// File: tb/tb_game_move_controller.sv
// Bench for game_move_controller: scenario tasks plus a move-request scoreboard.
// Requests are predicted when the key is driven and checked when move_req rises.
module tb_game_move_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic keyboard_locker = 1'b0;
  logic [2:0] keyboard_data = 3'd0;
  logic move_req;
  logic move_ack = 1'b0;
  logic move_ok = 1'b0;
  logic [3:0] move_src_x, move_src_y;
  logic [1:0] move_dir;
  logic move_half;
  logic [3:0] cursor_x, cursor_y;
  logic selected, cur_player, turn_switch;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] d;
    logic h;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  exp_t got;
  logic req_prev = 1'b0;

  game_move_controller #(
    .BORAD_WIDTH(10),
    .MOVES_PER_TURN(3),
    .TURN_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .keyboard_locker(keyboard_locker),
    .keyboard_data(keyboard_data),
    .move_req(move_req),
    .move_ack(move_ack),
    .move_ok(move_ok),
    .move_src_x(move_src_x),
    .move_src_y(move_src_y),
    .move_dir(move_dir),
    .move_half(move_half),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .selected(selected),
    .cur_player(cur_player),
    .turn_switch(turn_switch)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    got = {move_src_x, move_src_y, move_dir, move_half};
    if (move_req && !req_prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected got %h", got);
      end else begin
        cur_exp = sb.pop_front();
        if (got !== cur_exp) begin
          errors++;
          $display("FAIL req_fields got %h exp %h", got, cur_exp);
        end
      end
    end else if (move_req && req_prev) begin
      checks++;
      if (got !== cur_exp) begin
        errors++;
        $display("FAIL req_stable got %h exp %h", got, cur_exp);
      end
    end
    req_prev = move_req;
  end

  task automatic send_key(input logic [2:0] c);
    keyboard_data = c;
    keyboard_locker = 1'b1;
    @(negedge clk);
    keyboard_locker = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_ack(input logic ok);
    move_ack = 1'b1;
    move_ok = ok;
    @(negedge clk);
    move_ack = 1'b0;
    move_ok = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({move_req, cursor_x, cursor_y, selected, cur_player, turn_switch}
        !== 12'h0) begin
      errors++;
      $display("FAIL reset_state got %b %h %h %b %b %b exp 0", move_req,
               cursor_x, cursor_y, selected, cur_player, turn_switch);
    end
    checks++;
    if ({move_src_x, move_src_y, move_dir, move_half} !== 11'h0) begin
      errors++;
      $display("FAIL reset_move got %h exp 0",
               {move_src_x, move_src_y, move_dir, move_half});
    end
  endtask

  task automatic test_timeout_idle;
    logic early;
    early = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 999; i++) begin
      @(negedge clk);
      if (turn_switch) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0 || cur_player !== 1'b0) begin
      errors++;
      $display("FAIL idle_early got sw=%b ply=%b exp 0 0", early, cur_player);
    end
    @(negedge clk);
    checks++;
    if (turn_switch !== 1'b1 || cur_player !== 1'b1) begin
      errors++;
      $display("FAIL idle_switch got sw=%b ply=%b exp 1 1",
               turn_switch, cur_player);
    end
    @(negedge clk);
    checks++;
    if (turn_switch !== 1'b0) begin
      errors++;
      $display("FAIL idle_pulse got %b exp 0", turn_switch);
    end
  endtask

  task automatic test_cursor;
    repeat (3) send_key(3'd2);
    repeat (2) send_key(3'd0);
    checks++;
    if ({cursor_x, cursor_y} !== 8'h00) begin
      errors++;
      $display("FAIL clamp_low got %h exp 00", {cursor_x, cursor_y});
    end
    repeat (12) send_key(3'd3);
    checks++;
    if ({cursor_x, cursor_y} !== 8'h90) begin
      errors++;
      $display("FAIL clamp_high got %h exp 90", {cursor_x, cursor_y});
    end
    repeat (5) send_key(3'd2);
    keyboard_data = 3'd1;
    keyboard_locker = 1'b1;
    repeat (4) @(negedge clk);
    keyboard_locker = 1'b0;
    @(negedge clk);
    checks++;
    if ({cursor_x, cursor_y} !== 8'h41) begin
      errors++;
      $display("FAIL held_key got %h exp 41", {cursor_x, cursor_y});
    end
    repeat (3) send_key(3'd1);
    checks++;
    if ({cursor_x, cursor_y} !== 8'h44) begin
      errors++;
      $display("FAIL cursor_44 got %h exp 44", {cursor_x, cursor_y});
    end
  endtask

  task automatic test_move_basic;
    send_key(3'd4);
    checks++;
    if (selected !== 1'b1) begin
      errors++;
      $display("FAIL select got %b exp 1", selected);
    end
    sb.push_back('{x: 4'd4, y: 4'd4, d: 2'd3, h: 1'b0});
    send_key(3'd3);
    checks++;
    if (move_req !== 1'b1) begin
      errors++;
      $display("FAIL req_raise got %b exp 1", move_req);
    end
    repeat (5) @(negedge clk);
    do_ack(1'b1);
    checks++;
    if ({move_req, selected, cursor_x, cursor_y} !== {2'b01, 8'h54}) begin
      errors++;
      $display("FAIL ack_ok got %b %b %h exp 0 1 54", move_req, selected,
               {cursor_x, cursor_y});
    end
  endtask

  task automatic test_wait_ack_ignore;
    sb.push_back('{x: 4'd5, y: 4'd4, d: 2'd1, h: 1'b0});
    send_key(3'd1);
    send_key(3'd2);
    send_key(3'd0);
    send_key(3'd4);
    send_key(3'd7);
    checks++;
    if ({move_req, cursor_x, cursor_y} !== {1'b1, 8'h54}) begin
      errors++;
      $display("FAIL wait_ignore got %b %h exp 1 54", move_req,
               {cursor_x, cursor_y});
    end
    do_ack(1'b0);
    checks++;
    if ({move_req, selected, cursor_x, cursor_y} !== {2'b01, 8'h54}) begin
      errors++;
      $display("FAIL ack_reject got %b %b %h exp 0 1 54", move_req,
               selected, {cursor_x, cursor_y});
    end
    sb.push_back('{x: 4'd5, y: 4'd4, d: 2'd2, h: 1'b0});
    send_key(3'd2);
    do_ack(1'b1);
    checks++;
    if ({selected, cursor_x, cursor_y, cur_player} !== {1'b1, 8'h44, 1'b1})
    begin
      errors++;
      $display("FAIL reject_then_ok got %b %h %b exp 1 44 1", selected,
               {cursor_x, cursor_y}, cur_player);
    end
  endtask

  task automatic test_end_turn;
    keyboard_data = 3'd6;
    keyboard_locker = 1'b1;
    @(negedge clk);
    keyboard_locker = 1'b0;
    checks++;
    if ({turn_switch, cur_player, selected, cursor_x, cursor_y}
        !== {3'b100, 8'h44}) begin
      errors++;
      $display("FAIL end_turn got %b %b %b %h exp 1 0 0 44", turn_switch,
               cur_player, selected, {cursor_x, cursor_y});
    end
    @(negedge clk);
    checks++;
    if (turn_switch !== 1'b0) begin
      errors++;
      $display("FAIL end_pulse got %b exp 0", turn_switch);
    end
  endtask

  task automatic test_three_moves;
    send_key(3'd4);
    sb.push_back('{x: 4'd4, y: 4'd4, d: 2'd3, h: 1'b0});
    send_key(3'd3);
    do_ack(1'b1);
    sb.push_back('{x: 4'd5, y: 4'd4, d: 2'd3, h: 1'b0});
    send_key(3'd3);
    do_ack(1'b1);
    checks++;
    if ({cur_player, selected, cursor_x, cursor_y} !== {2'b01, 8'h64}) begin
      errors++;
      $display("FAIL chain_two got %b %b %h exp 0 1 64", cur_player,
               selected, {cursor_x, cursor_y});
    end
    sb.push_back('{x: 4'd6, y: 4'd4, d: 2'd3, h: 1'b0});
    send_key(3'd3);
    do_ack(1'b1);
    checks++;
    if ({turn_switch, cur_player, selected, cursor_x, cursor_y}
        !== {3'b110, 8'h74}) begin
      errors++;
      $display("FAIL budget_switch got %b %b %b %h exp 1 1 0 74",
               turn_switch, cur_player, selected, {cursor_x, cursor_y});
    end
    @(negedge clk);
    checks++;
    if (turn_switch !== 1'b0) begin
      errors++;
      $display("FAIL budget_pulse got %b exp 0", turn_switch);
    end
  endtask

  task automatic test_edge_half;
    repeat (7) send_key(3'd2);
    repeat (4) send_key(3'd0);
    send_key(3'd4);
    send_key(3'd0);
    send_key(3'd2);
    checks++;
    if ({move_req, selected, cursor_x, cursor_y} !== {2'b01, 8'h00}) begin
      errors++;
      $display("FAIL off_board got %b %b %h exp 0 1 00", move_req,
               selected, {cursor_x, cursor_y});
    end
    send_key(3'd5);
    sb.push_back('{x: 4'd0, y: 4'd0, d: 2'd3, h: 1'b1});
    send_key(3'd3);
    do_ack(1'b1);
    checks++;
    if ({cursor_x, cursor_y} !== 8'h10) begin
      errors++;
      $display("FAIL half_move got %h exp 10", {cursor_x, cursor_y});
    end
    sb.push_back('{x: 4'd1, y: 4'd0, d: 2'd1, h: 1'b0});
    send_key(3'd1);
    do_ack(1'b0);
    send_key(3'd7);
    checks++;
    if ({selected, move_req, cursor_x, cursor_y} !== {2'b00, 8'h10}) begin
      errors++;
      $display("FAIL cancel got %b %b %h exp 0 0 10", selected, move_req,
               {cursor_x, cursor_y});
    end
  endtask

  task automatic test_deferred_timeout;
    int n;
    logic early;
    n = 0;
    while (!turn_switch && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (turn_switch !== 1'b1 || cur_player !== 1'b0) begin
      errors++;
      $display("FAIL timeout_wait got sw=%b ply=%b exp 1 0", turn_switch,
               cur_player);
    end
    keyboard_data = 3'd4;
    keyboard_locker = 1'b1;
    @(negedge clk);
    keyboard_locker = 1'b0;
    repeat (997) @(negedge clk);
    sb.push_back('{x: 4'd1, y: 4'd0, d: 2'd3, h: 1'b0});
    keyboard_data = 3'd3;
    keyboard_locker = 1'b1;
    @(negedge clk);
    keyboard_locker = 1'b0;
    checks++;
    if (move_req !== 1'b1 || turn_switch !== 1'b0) begin
      errors++;
      $display("FAIL late_req got req=%b sw=%b exp 1 0", move_req,
               turn_switch);
    end
    early = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (turn_switch) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0 || cur_player !== 1'b0) begin
      errors++;
      $display("FAIL defer_early got sw=%b ply=%b exp 0 0", early,
               cur_player);
    end
    do_ack(1'b1);
    checks++;
    if ({turn_switch, cur_player, selected, move_req, cursor_x, cursor_y}
        !== {4'b1100, 8'h20}) begin
      errors++;
      $display("FAIL defer_switch got %b %b %b %b %h exp 1 1 0 0 20",
               turn_switch, cur_player, selected, move_req,
               {cursor_x, cursor_y});
    end
  endtask

  task automatic test_timeout_wins;
    repeat (999) @(negedge clk);
    keyboard_data = 3'd3;
    keyboard_locker = 1'b1;
    @(negedge clk);
    keyboard_locker = 1'b0;
    checks++;
    if ({turn_switch, cur_player, cursor_x, cursor_y} !== {2'b10, 8'h20})
    begin
      errors++;
      $display("FAIL timeout_wins got %b %b %h exp 1 0 20", turn_switch,
               cur_player, {cursor_x, cursor_y});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    send_key(3'd4);
    sb.push_back('{x: 4'd2, y: 4'd0, d: 2'd1, h: 1'b0});
    send_key(3'd1);
    checks++;
    if (move_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req got %b exp 1", move_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({move_req, selected, cur_player, cursor_x, cursor_y} !== 11'h0) begin
      errors++;
      $display("FAIL async_reset got %b %b %b %h exp 0 0 0 00", move_req,
               selected, cur_player, {cursor_x, cursor_y});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_ack(1'b1);
    @(negedge clk);
    checks++;
    if ({move_req, selected, cursor_x, cursor_y} !== 10'h0) begin
      errors++;
      $display("FAIL stray_ack got %b %b %h exp 0 0 00", move_req,
               selected, {cursor_x, cursor_y});
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain got %0d exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_timeout_idle;
    test_cursor;
    test_move_basic;
    test_wait_ack_ignore;
    test_end_turn;
    test_three_moves;
    test_edge_half;
    test_deferred_timeout;
    test_timeout_wins;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
